// File: rtl/snn_window_ctrl.sv
// snn_window_ctrl -- sequences one SNN evaluation window:
//   IDLE -> CLEAR (snn_rst for CLR_LEN cycles) -> RUN (snn_en for WIN_LEN
//   cycles) -> DRAIN (1 cycle) -> REPORT (hold result until handshake).
// Spike counts use a one-cycle-shifted window (RUN cycles 2..WIN_LEN plus
// DRAIN), because the SNN registers its spike output one cycle after snn_en.
// Optional build macro: SNN_CTRL_AUTORUN_EN -- the REPORT handshake goes
// straight back to CLEAR, so windows repeat without a new start pulse.
// All outputs are registered; reset is synchronous, active-high.
module snn_window_ctrl #(
   parameter int WIN_LEN = 64,
   parameter int CLR_LEN = 2,
   parameter int CNT_W   = 8,
   parameter int MIN_SPK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       spike_in,
   output logic             snn_en,
   output logic             snn_rst,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_cmd,
   output logic [CNT_W-1:0] cnt_l,
   output logic [CNT_W-1:0] cnt_r
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_RUN    = 3'd2,
      S_DRAIN  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   localparam logic [15:0]      WIN_LAST = 16'(WIN_LEN - 1);
   localparam logic [3:0]       CLR_LAST = 4'(CLR_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Saturating increment: a counter at full scale stays there.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic s);
      if (s && (c != CNT_MAX)) begin
         return c + CNT_ONE;
      end else begin
         return c;
      end
   endfunction

   // Steering decision from the two window counts.
   function automatic logic [1:0] steer_cmd(input logic [CNT_W-1:0] l, input logic [CNT_W-1:0] r);
      if ((32'(l) < MIN_SPK) && (32'(r) < MIN_SPK)) begin
         return 2'b00;
      end else if (l > r) begin
         return 2'b01;
      end else if (r > l) begin
         return 2'b10;
      end else begin
         return 2'b11;
      end
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       clr_cnt_r;
   logic [15:0]      win_cnt_r;
   logic [CNT_W-1:0] acc_l_r;
   logic [CNT_W-1:0] acc_r_r;
   logic [CNT_W-1:0] acc_l_nxt_s;
   logic [CNT_W-1:0] acc_r_nxt_s;
   logic             clr_done_s;
   logic             win_done_s;
   logic             count_en_s;
   logic             snn_en_r;
   logic             snn_rst_r;
   logic             busy_r;
   logic             res_valid_r;
   logic [1:0]       res_cmd_r;
   logic [CNT_W-1:0] cnt_l_r;
   logic [CNT_W-1:0] cnt_r_r;

   assign clr_done_s = (clr_cnt_r == CLR_LAST);
   assign win_done_s = (win_cnt_r == WIN_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_CLEAR;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (clr_done_s) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_CLEAR;
            end
         end
         S_RUN: begin
            if (win_done_s) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_DRAIN: begin
            state_nxt_s = S_REPORT;
         end
         S_REPORT: begin
            // res_valid is always high in REPORT, so res_ready alone completes the handshake.
            if (res_ready) begin
`ifdef SNN_CTRL_AUTORUN_EN
               state_nxt_s = S_CLEAR;
`else
               state_nxt_s = S_IDLE;
`endif
            end else begin
               state_nxt_s = S_REPORT;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Cycle counters for the CLEAR and RUN phases; zero outside their phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt_r <= 4'd0;
         win_cnt_r <= 16'd0;
      end else begin
         if ((state_r == S_CLEAR) && !clr_done_s) begin
            clr_cnt_r <= clr_cnt_r + 4'd1;
         end else begin
            clr_cnt_r <= 4'd0;
         end
         if ((state_r == S_RUN) && !win_done_s) begin
            win_cnt_r <= win_cnt_r + 16'd1;
         end else begin
            win_cnt_r <= 16'd0;
         end
      end
   end

   // Spike sampling window: RUN cycles 2..WIN_LEN and the DRAIN cycle.
   always_comb begin
      count_en_s  = 1'b0;
      acc_l_nxt_s = acc_l_r;
      acc_r_nxt_s = acc_r_r;
      if (((state_r == S_RUN) && (win_cnt_r != 16'd0)) || (state_r == S_DRAIN)) begin
         count_en_s  = 1'b1;
      end else begin
         count_en_s  = 1'b0;
      end
      if (count_en_s) begin
         acc_l_nxt_s = sat_inc(acc_l_r, spike_in[0]);
         acc_r_nxt_s = sat_inc(acc_r_r, spike_in[1]);
      end else begin
         acc_l_nxt_s = acc_l_r;
         acc_r_nxt_s = acc_r_r;
      end
   end

   // Working spike accumulators, cleared during CLEAR.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_l_r <= '0;
         acc_r_r <= '0;
      end else if (state_r == S_CLEAR) begin
         acc_l_r <= '0;
         acc_r_r <= '0;
      end else begin
         acc_l_r <= acc_l_nxt_s;
         acc_r_r <= acc_r_nxt_s;
      end
   end

   // Result capture on DRAIN exit, including the DRAIN-cycle spike; held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_l_r   <= '0;
         cnt_r_r   <= '0;
         res_cmd_r <= 2'b00;
      end else if (state_r == S_DRAIN) begin
         cnt_l_r   <= acc_l_nxt_s;
         cnt_r_r   <= acc_r_nxt_s;
         res_cmd_r <= steer_cmd(acc_l_nxt_s, acc_r_nxt_s);
      end else begin
         cnt_l_r   <= cnt_l_r;
         cnt_r_r   <= cnt_r_r;
         res_cmd_r <= res_cmd_r;
      end
   end

   // Control outputs registered from the next state so they align with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         snn_en_r    <= 1'b0;
         snn_rst_r   <= 1'b1;
         busy_r      <= 1'b0;
         res_valid_r <= 1'b0;
      end else begin
         snn_en_r    <= (state_nxt_s == S_RUN);
         snn_rst_r   <= (state_nxt_s == S_CLEAR);
         busy_r      <= (state_nxt_s != S_IDLE);
         res_valid_r <= (state_nxt_s == S_REPORT);
      end
   end

   assign snn_en    = snn_en_r;
   assign snn_rst   = snn_rst_r;
   assign busy      = busy_r;
   assign res_valid = res_valid_r;
   assign res_cmd   = res_cmd_r;
   assign cnt_l     = cnt_l_r;
   assign cnt_r     = cnt_r_r;

endmodule

// File: tb/tb_snn_window_ctrl.sv
// Testbench for snn_window_ctrl: vector table, hand-written corner
// sequences, and a randomized run checked every cycle against a timeline
// model (position since start) of the window controller.
module tb_snn_window_ctrl;

   localparam int WIN  = 8;
   localparam int CLR  = 2;
   localparam int CW   = 4;
   localparam int MINS = 2;
   localparam int SMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, start, res_ready;
   logic [1:0]    spike_in;
   logic          snn_en, snn_rst, busy, res_valid;
   logic [1:0]    res_cmd;
   logic [CW-1:0] cnt_l, cnt_r;

   logic          s2_rst, s2_start, s2_ready;
   logic [1:0]    s2_spike;
   logic          s2_en, s2_srst, s2_busy, s2_valid;
   logic [1:0]    s2_cmd;
   logic [CW-1:0] s2_cnt_l, s2_cnt_r;

   int checks = 0;
   int errors = 0;
   bit model_chk = 1'b0;

   always #5 clk = ~clk;

   snn_window_ctrl #(.WIN_LEN(WIN), .CLR_LEN(CLR), .CNT_W(CW), .MIN_SPK(MINS)) dut (
      .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
      .snn_en(snn_en), .snn_rst(snn_rst), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_cmd(res_cmd), .cnt_l(cnt_l), .cnt_r(cnt_r));

   snn_window_ctrl #(.WIN_LEN(20), .CLR_LEN(CLR), .CNT_W(CW), .MIN_SPK(MINS)) dut_sat (
      .clk(clk), .rst(s2_rst), .start(s2_start), .spike_in(s2_spike),
      .snn_en(s2_en), .snn_rst(s2_srst), .busy(s2_busy), .res_valid(s2_valid),
      .res_ready(s2_ready), .res_cmd(s2_cmd), .cnt_l(s2_cnt_l), .cnt_r(s2_cnt_r));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_cmd(input int l, input int r);
      if (l < MINS && r < MINS) return 0;
      else if (l > r) return 1;
      else if (r > l) return 2;
      else return 3;
   endfunction

   // Reference model: m_t is the position of the current cycle counted from the
   // start edge (1 = first clear cycle). Window phases follow from plain arithmetic.
   bit m_active = 1'b0;
   bit m_rstout = 1'b1;
   int m_t = 0, m_al = 0, m_ar = 0, m_cl = 0, m_cr = 0, m_cmd = 0;

   always @(posedge clk) begin : model_upd
      int t, al, ar, cl, cr, cmd;
      bit act;
      t = m_t; al = m_al; ar = m_ar; cl = m_cl; cr = m_cr; cmd = m_cmd; act = m_active;
      if (rst) begin
         act = 1'b0; cl = 0; cr = 0; cmd = 0;
         m_rstout <= 1'b1;
      end else begin
         m_rstout <= 1'b0;
         if (!act) begin
            if (start) begin
               act = 1'b1; t = 1; al = 0; ar = 0;
            end
         end else begin
            if (t >= CLR + 2 && t <= CLR + WIN + 1) begin
               al += int'(spike_in[0]);
               ar += int'(spike_in[1]);
            end
            if (t == CLR + WIN + 1) begin
               cl = (al > SMAX) ? SMAX : al;
               cr = (ar > SMAX) ? SMAX : ar;
               cmd = ref_cmd(cl, cr);
            end
            if (t >= CLR + WIN + 2 && res_ready) begin
`ifdef SNN_CTRL_AUTORUN_EN
               t = 1; al = 0; ar = 0;
`else
               act = 1'b0;
`endif
            end else begin
               t++;
            end
         end
      end
      m_t <= t; m_al <= al; m_ar <= ar; m_cl <= cl; m_cr <= cr; m_cmd <= cmd; m_active <= act;
   end

   // Per-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      logic [13:0] act_v, exp_v;
      if (model_chk) begin
         act_v = {snn_en, snn_rst, busy, res_valid, res_cmd, cnt_l, cnt_r};
         exp_v = {m_active && m_t > CLR && m_t <= CLR + WIN,
                  m_rstout || (m_active && m_t <= CLR),
                  m_active,
                  m_active && m_t >= CLR + WIN + 2,
                  2'(m_cmd), CW'(m_cl), CW'(m_cr)};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cycle: got %h expected %h (t=%0d)", act_v, exp_v, m_t);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   // One window with res_ready=1; spk is driven constantly or only at position once_at.
   task automatic run_window(input logic [1:0] spk, input int once_at,
                             output int lat, output int l, output int r, output int cmd,
                             output int en_n, output int rs_n, output int val_n);
      lat = -1; l = -1; r = -1; cmd = -1; en_n = 0; rs_n = 0; val_n = 0;
      res_ready = 1'b1;
      @(negedge clk) start = 1'b1; spike_in = 2'b00;
      @(negedge clk) start = 1'b0;
      for (int t = 1; t <= 60; t++) begin
         spike_in = (once_at < 0 || once_at == t) ? spk : 2'b00;
         if (lat >= 0 && !res_valid) break;
         if (snn_en) en_n++;
         if (snn_rst) rs_n++;
         if (res_valid) begin
            val_n++;
            if (lat < 0) begin
               lat = t; l = int'(cnt_l); r = int'(cnt_r); cmd = int'(res_cmd);
            end
         end
         @(negedge clk);
      end
      spike_in = 2'b00;
`ifdef SNN_CTRL_AUTORUN_EN
      do_reset();
`else
      chk("idle_after_hs", int'(busy), 0);
`endif
   endtask

   typedef struct {
      logic [1:0] spk;
      int         once_at;
      int         exp_l;
      int         exp_r;
      int         exp_cmd;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int lat, l, r, cmd, en_n, rs_n, val_n;
      int vt [3];
      int nv;

      tbl[0] = '{2'b01, -1, 8, 0, 1};
      tbl[1] = '{2'b11, -1, 8, 8, 3};
      tbl[2] = '{2'b10,  5, 0, 1, 0};
      tbl[3] = '{2'b10, -1, 0, 8, 2};
      tbl[4] = '{2'b01,  3, 0, 0, 0};   // spike in first RUN cycle is outside the window
      tbl[5] = '{2'b01, 11, 1, 0, 0};   // spike in DRAIN is inside the window
      tbl[6] = '{2'b00, -1, 0, 0, 0};

      rst = 1'b1; start = 1'b0; spike_in = 2'b00; res_ready = 1'b1;
      s2_rst = 1'b1; s2_start = 1'b0; s2_spike = 2'b00; s2_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_snn_en", int'(snn_en), 0);
      chk("rst_snn_rst", int'(snn_rst), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_cmd", int'(res_cmd), 0);
      chk("rst_cnt_l", int'(cnt_l), 0);
      chk("rst_cnt_r", int'(cnt_r), 0);
      model_chk = 1'b1;
      rst = 1'b0; s2_rst = 1'b0;
      @(negedge clk);
      chk("snn_rst_release", int'(snn_rst), 0);

      // Vector table
      for (int i = 0; i < 7; i++) begin
         run_window(tbl[i].spk, tbl[i].once_at, lat, l, r, cmd, en_n, rs_n, val_n);
         chk($sformatf("tbl%0d_cnt_l", i), l, tbl[i].exp_l);
         chk($sformatf("tbl%0d_cnt_r", i), r, tbl[i].exp_r);
         chk($sformatf("tbl%0d_cmd", i), cmd, tbl[i].exp_cmd);
         chk($sformatf("tbl%0d_latency", i), lat, CLR + WIN + 2);
         chk($sformatf("tbl%0d_en_cycles", i), en_n, WIN);
         chk($sformatf("tbl%0d_rst_cycles", i), rs_n, CLR);
         chk($sformatf("tbl%0d_valid_cycles", i), val_n, 1);
      end

      // Backpressure: result held for 5 REPORT cycles, start ignored
      res_ready = 1'b0;
      @(negedge clk) start = 1'b1; spike_in = 2'b01;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
      chk("bp_valid_seen", int'(res_valid), 1);
      for (int k = 0; k < 5; k++) begin
         start = (k == 1 || k == 3);
         chk("bp_valid_held", int'(res_valid), 1);
         chk("bp_busy", int'(busy), 1);
         chk("bp_cnt_l", int'(cnt_l), 8);
         chk("bp_cnt_r", int'(cnt_r), 0);
         chk("bp_cmd", int'(res_cmd), 1);
         @(negedge clk);
      end
      start = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", int'(res_valid), 0);
`ifdef SNN_CTRL_AUTORUN_EN
      chk("bp_autoclear", int'(snn_rst), 1);
      do_reset();
`else
      chk("bp_idle", int'(busy), 0);
      @(negedge clk);
      chk("bp_stay_idle", int'(busy), 0);
`endif
      spike_in = 2'b00;

      // Reset in RUN cycle 4
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0; spike_in = 2'b11;
      repeat (5) @(negedge clk);
      chk("mid_in_run", int'(snn_en), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_snn_en", int'(snn_en), 0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_cnt_l", int'(cnt_l), 0);
      chk("mid_cnt_r", int'(cnt_r), 0);
      chk("mid_snn_rst", int'(snn_rst), 1);
      rst = 1'b0; spike_in = 2'b00;
      run_window(2'b01, -1, lat, l, r, cmd, en_n, rs_n, val_n);
      chk("post_rst_cnt_l", l, 8);
      chk("post_rst_cnt_r", r, 0);
      chk("post_rst_cmd", cmd, 1);
      chk("post_rst_latency", lat, CLR + WIN + 2);
      chk("post_rst_en_cycles", en_n, WIN);

      // Saturation on the WIN_LEN=20 instance
      @(negedge clk) s2_start = 1'b1; s2_spike = 2'b01;
      @(negedge clk) s2_start = 1'b0;
      lat = -1;
      for (int t = 1; t <= 60; t++) begin
         if (s2_valid) begin
            lat = t; break;
         end
         @(negedge clk);
      end
      chk("sat_latency", lat, CLR + 20 + 2);
      chk("sat_cnt_l", int'(s2_cnt_l), SMAX);
      chk("sat_cnt_r", int'(s2_cnt_r), 0);
      chk("sat_cmd", int'(s2_cmd), 1);
      s2_rst = 1'b1;

`ifdef SNN_CTRL_AUTORUN_EN
      // Autorun: one start, three back-to-back windows
      nv = 0;
      @(negedge clk) start = 1'b1; spike_in = 2'b01; res_ready = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int t = 1; t <= 80 && nv < 3; t++) begin
         if (res_valid) begin
            vt[nv] = t; nv++;
            @(negedge clk);
            chk("auto_clear_follow", int'(snn_rst), 1);
            chk("auto_cnt_l", int'(cnt_l), 8);
         end else begin
            @(negedge clk);
         end
      end
      chk("auto_windows", nv, 3);
      if (nv == 3) begin
         chk("auto_first_lat", vt[0], CLR + WIN + 2);
         chk("auto_period1", vt[1] - vt[0], CLR + WIN + 2);
         chk("auto_period2", vt[2] - vt[1], CLR + WIN + 2);
      end
      spike_in = 2'b00;
      do_reset();
`endif

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 3) == 0);
         spike_in  = 2'($urandom_range(0, 3));
         res_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      model_chk = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
